// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the MIPS datapath: FETCH, DECODE, EXEC, WB per instruction.
// All outputs are registered Moore outputs, and illegal encodings are trapped or retired as NOPs.
module unidade_controle #(
  parameter int unsigned CNT_W           = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic             en,
  output logic             en_rf,
  output logic             selec_mux,
  output logic             selec_mux2,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state;
  logic       lat_wr;
  logic       lat_ill;

  logic       dec_legal;
  logic       dec_nop;
  logic       dec_mux;
  logic       dec_mux2;
  logic [3:0] dec_alu;

  always_comb begin
    dec_legal = 1'b1;
    dec_nop   = 1'b0;
    dec_mux   = 1'b0;
    dec_mux2  = 1'b0;
    dec_alu   = ALU_AND;
    if (op == 6'h00) begin
      dec_mux = 1'b1;
      case (funct)
        6'h20:   dec_alu = ALU_ADD;
        6'h22:   dec_alu = ALU_SUB;
        6'h24:   dec_alu = ALU_AND;
        6'h25:   dec_alu = ALU_OR;
        6'h27:   dec_alu = ALU_NOR;
        6'h2A:   dec_alu = ALU_SLT;
        6'h00:   dec_nop = 1'b1;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_mux2 = 1'b1;
      case (op)
        6'h08:   dec_alu = ALU_ADD;
        6'h0C:   dec_alu = ALU_AND;
        6'h0D:   dec_alu = ALU_OR;
        6'h0A:   dec_alu = ALU_SLT;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Outputs are assigned on the edge that enters the state they belong to,
  // so each state's outputs are visible for that whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      en          <= 1'b0;
      en_rf       <= 1'b0;
      selec_mux   <= 1'b0;
      selec_mux2  <= 1'b0;
      alu_op      <= '0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
      lat_wr      <= 1'b0;
      lat_ill     <= 1'b0;
    end else begin
      en    <= 1'b0;
      en_rf <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          lat_wr  <= dec_legal & ~dec_nop;
          lat_ill <= ~dec_legal;
          if (!dec_legal && HALT_ON_ILLEGAL) begin
            state   <= S_TRAP;
            busy    <= 1'b0;
            illegal <= 1'b1;
          end else begin
            state <= S_EXEC;
            // NOP and illegal encodings leave the selects at their last values.
            if (dec_legal && !dec_nop) begin
              selec_mux  <= dec_mux;
              selec_mux2 <= dec_mux2;
              alu_op     <= dec_alu;
            end
          end
        end
        S_EXEC: begin
          state       <= S_WB;
          en          <= 1'b1;
          en_rf       <= lat_wr;
          illegal     <= lat_ill;
          instr_count <= instr_count + 1'b1;
        end
        S_WB: begin
          illegal <= 1'b0;
          busy    <= run;
          state   <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP: begin
          state   <= S_TRAP;
          busy    <= 1'b0;
          illegal <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
